gp_sum_stage: RTL and testbench

Registered sum stage directly downstream of the 22-bit Brent-Kung group generate/propagate network. It takes the following per-bit inputs:
- half-sum `p`, the per-bit XOR;
- prefix group terms `G`/`P`, bit i spanning bits i..1;
- carry-in.

From these it forms carries and sum bits, and buffers results in a 2-entry output queue with valid/ready handshake. It is the last stage of the prefix adder pipeline, feeding the ALU result mux.

---
 rtl/gp_adder_pkg.sv | 23 ++
 rtl/gp_sum_stage_if.sv | 37 +++
 rtl/gp_carry_sum.sv | 28 ++
 rtl/gp_sum_stage.sv | 85 ++++++++
 tb/tb_gp_sum_stage.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/gp_adder_pkg.sv
// Shared types and sizes for the prefix adder sum stage.
// GP_SUM_OVF_EN adds a signed-overflow bit to each stored result.
package gp_adder_pkg;

  localparam int GP_WIDTH = 22;
  localparam int TX_CNT_W = 16;

  typedef struct packed {
    logic [GP_WIDTH:1] sum;
    logic              cout;
`ifdef GP_SUM_OVF_EN
    logic              ovf;
`endif
  } gp_result_t;

  // Queue occupancy doubles as the FSM state: EMPTY=0, HALF=1, FULL=2 entries.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } gp_q_state_e;

endpackage

// File: rtl/gp_sum_stage_if.sv
// Handshake bundle of the sum stage: operand input side, result output side, pop counter.
// out_ovf exists only when GP_SUM_OVF_EN is defined.
interface gp_sum_stage_if;
  import gp_adder_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [GP_WIDTH:1]   in_hs;
  logic [GP_WIDTH:1]   in_G;
  logic [GP_WIDTH:1]   in_P;
  logic                in_cin;
  logic                out_valid;
  logic                out_ready;
  logic [GP_WIDTH:1]   out_sum;
  logic                out_cout;
`ifdef GP_SUM_OVF_EN
  logic                out_ovf;
`endif
  logic [TX_CNT_W-1:0] tx_cnt;

  modport slave (
    input  in_valid, in_hs, in_G, in_P, in_cin, out_ready,
`ifdef GP_SUM_OVF_EN
    output out_ovf,
`endif
    output in_ready, out_valid, out_sum, out_cout, tx_cnt
  );

  modport master (
    output in_valid, in_hs, in_G, in_P, in_cin, out_ready,
`ifdef GP_SUM_OVF_EN
    input  out_ovf,
`endif
    input  in_ready, out_valid, out_sum, out_cout, tx_cnt
  );

endinterface

// File: rtl/gp_carry_sum.sv
// Combinational carry/sum formation from prefix group terms; G/P[i] span bits i..1.
// GP_SUM_OVF_EN also derives signed overflow from the top two carries.
module gp_carry_sum
  import gp_adder_pkg::*;
(
  input  logic [GP_WIDTH:1] i_hs,
  input  logic [GP_WIDTH:1] i_g,
  input  logic [GP_WIDTH:1] i_p,
  input  logic              i_cin,
  output gp_result_t        o_res
);

  // w_c[0] is carry-in; w_c[i] is the carry out of bit i.
  logic [GP_WIDTH:0] w_c;

  assign w_c = {i_g | (i_p & {GP_WIDTH{i_cin}}), i_cin};

  // Sum bit i uses the carry into it, i.e. out of bit i-1.
  always_comb begin
    o_res      = '0;
    o_res.sum  = i_hs ^ w_c[GP_WIDTH-1:0];
    o_res.cout = w_c[GP_WIDTH];
`ifdef GP_SUM_OVF_EN
    o_res.ovf  = w_c[GP_WIDTH] ^ w_c[GP_WIDTH-1];
`endif
  end

endmodule

// File: rtl/gp_sum_stage.sv
// Last prefix-adder stage: forms sums and buffers them in a 2-entry valid/ready queue.
// GP_SUM_OVF_EN adds a stored signed-overflow bit and the out_ovf port.
module gp_sum_stage
  import gp_adder_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  gp_sum_stage_if.slave  bus
);

  gp_result_t          w_res;
  gp_result_t          w_head;
  gp_result_t          r_mem [0:1];
  gp_q_state_e         r_state;
  logic                r_head;
  logic                r_tail;
  logic [TX_CNT_W-1:0] r_tx_cnt;
  logic                w_push;
  logic                w_pop;

  gp_carry_sum u_carry_sum (
    .i_hs  (bus.in_hs),
    .i_g   (bus.in_G),
    .i_p   (bus.in_P),
    .i_cin (bus.in_cin),
    .o_res (w_res)
  );

  // Handshake flags decode only registered state, so in_ready never sees out_ready.
  assign bus.in_ready  = (r_state != ST_FULL);
  assign bus.out_valid = (r_state != ST_EMPTY);
  assign w_push        = bus.in_valid & bus.in_ready;
  assign w_pop         = bus.out_valid & bus.out_ready;

  assign w_head        = r_mem[r_head];
  assign bus.out_sum   = w_head.sum;
  assign bus.out_cout  = w_head.cout;
`ifdef GP_SUM_OVF_EN
  assign bus.out_ovf   = w_head.ovf;
`endif
  assign bus.tx_cnt    = r_tx_cnt;

  // Queue storage, pointers, pop counter and occupancy FSM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_EMPTY;
      r_head   <= 1'b0;
      r_tail   <= 1'b0;
      r_tx_cnt <= '0;
      r_mem[0] <= '0;
      r_mem[1] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_tail] <= w_res;
        r_tail        <= ~r_tail;
      end else begin
        r_tail        <= r_tail;
      end
      if (w_pop) begin
        r_head   <= ~r_head;
        r_tx_cnt <= r_tx_cnt + TX_CNT_W'(1);
      end else begin
        r_head   <= r_head;
        r_tx_cnt <= r_tx_cnt;
      end
      case (r_state)
        ST_EMPTY: begin
          if (w_push) r_state <= ST_HALF;
          else        r_state <= ST_EMPTY;
        end
        ST_HALF: begin
          if (w_push && !w_pop)      r_state <= ST_FULL;
          else if (!w_push && w_pop) r_state <= ST_EMPTY;
          else                       r_state <= ST_HALF;
        end
        ST_FULL: begin
          if (w_pop) r_state <= ST_HALF;
          else       r_state <= ST_FULL;
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_gp_sum_stage.sv
// Self-checking bench for gp_sum_stage: arithmetic scoreboard model plus directed literal checks.
// Overflow comparisons are built only when GP_SUM_OVF_EN is defined.
module tb_gp_sum_stage;
  import gp_adder_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  gp_sum_stage_if bus ();

  gp_sum_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [21:0] cur_a, cur_b;
  logic        cur_cin;
  logic [23:0] q[$];          // {ovf, cout, sum[21:0]}
  logic [15:0] m_tx;
  bit          m_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Group generate over bits 0..j is the carry out of the partial sum of those bits.
  function automatic logic [21:0] mk_g(input logic [21:0] a, input logic [21:0] b);
    logic [22:0] s;
    logic [21:0] m;
    mk_g = '0;
    for (int j = 0; j < 22; j++) begin
      m = 22'((23'd1 << (j + 1)) - 23'd1);
      s = {1'b0, a & m} + {1'b0, b & m};
      mk_g[j] = s[j+1];
    end
  endfunction

  function automatic logic [21:0] mk_p(input logic [21:0] a, input logic [21:0] b);
    logic [21:0] m;
    mk_p = '0;
    for (int j = 0; j < 22; j++) begin
      m = 22'((23'd1 << (j + 1)) - 23'd1);
      mk_p[j] = (((a ^ b) & m) == m);
    end
  endfunction

  function automatic logic [23:0] expect_res(input logic [21:0] a, input logic [21:0] b, input logic cin);
    logic [22:0] t;
    logic        ovf;
    t   = {1'b0, a} + {1'b0, b} + {22'd0, cin};
    ovf = (a[21] == b[21]) && (t[21] != a[21]);
    return {ovf, t[22], t[21:0]};
  endfunction

  task automatic offer(input logic [21:0] a, input logic [21:0] b, input logic cin);
    cur_a = a; cur_b = b; cur_cin = cin;
    bus.in_hs    = a ^ b;
    bus.in_G     = mk_g(a, b);
    bus.in_P     = mk_p(a, b);
    bus.in_cin   = cin;
    bus.in_valid = 1'b1;
  endtask

  task automatic offer_rand();
    offer(22'($urandom()), 22'($urandom()), 1'($urandom_range(1)));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare outputs against the model, then apply the handshakes of the coming edge.
  always @(negedge clk) begin
    if (m_on) begin
      chk("in_ready", {31'd0, bus.in_ready}, {31'd0, q.size() < 2});
      chk("out_valid", {31'd0, bus.out_valid}, {31'd0, q.size() != 0});
      chk("tx_cnt", {16'd0, bus.tx_cnt}, {16'd0, m_tx});
      if (q.size() != 0) begin
        chk("out_sum", {10'd0, bus.out_sum}, {10'd0, q[0][21:0]});
        chk("out_cout", {31'd0, bus.out_cout}, {31'd0, q[0][22]});
`ifdef GP_SUM_OVF_EN
        chk("out_ovf", {31'd0, bus.out_ovf}, {31'd0, q[0][23]});
`endif
      end
    end
    if (!rst_n) begin
      q.delete();
      m_tx = 16'd0;
      m_on = 1'b1;
    end else if (m_on) begin
      if (bus.out_valid && bus.out_ready && q.size() != 0) begin
        void'(q.pop_front());
        m_tx = m_tx + 16'd1;
      end
      if (bus.in_valid && bus.in_ready) q.push_back(expect_res(cur_a, cur_b, cur_cin));
    end
  end

  initial begin
    logic acc;
    int   sent;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_hs = '0; bus.in_G = '0; bus.in_P = '0; bus.in_cin = 1'b0;
    cur_a = '0; cur_b = '0; cur_cin = 1'b0;
    step(); step();
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_sum", {10'd0, bus.out_sum}, 32'd0);
    chk("rst_tx_cnt", {16'd0, bus.tx_cnt}, 32'd0);
    rst_n = 1'b1;
    step();

    // Carry rippling through every bit.
    bus.out_ready = 1'b1;
    offer(22'h3FFFFF, 22'h000001, 1'b0);
    step(); bus.in_valid = 1'b0;
    chk("t1_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("t1_sum", {10'd0, bus.out_sum}, 32'h000000);
    chk("t1_cout", {31'd0, bus.out_cout}, 32'd1);
`ifdef GP_SUM_OVF_EN
    chk("t1_ovf", {31'd0, bus.out_ovf}, 32'd0);
`endif
    step();
    chk("t1_tx", {16'd0, bus.tx_cnt}, 32'd1);

    // Positive overflow into the sign bit.
    offer(22'h1FFFFF, 22'h000001, 1'b0);
    step(); bus.in_valid = 1'b0;
    chk("t2_sum", {10'd0, bus.out_sum}, 32'h200000);
    chk("t2_cout", {31'd0, bus.out_cout}, 32'd0);
`ifdef GP_SUM_OVF_EN
    chk("t2_ovf", {31'd0, bus.out_ovf}, 32'd1);
`endif
    step();

    // Carry-in alone.
    offer(22'h000000, 22'h000000, 1'b1);
    step(); bus.in_valid = 1'b0;
    chk("t3_sum", {10'd0, bus.out_sum}, 32'h000001);
    chk("t3_cout", {31'd0, bus.out_cout}, 32'd0);
    step();
    chk("t3_tx", {16'd0, bus.tx_cnt}, 32'd3);

    // Backpressure: two absorbed, third held until the first pop frees a slot.
    bus.out_ready = 1'b0;
    offer(22'd1, 22'd1, 1'b0);
    step();
    chk("bp_ready1", {31'd0, bus.in_ready}, 32'd1);
    offer(22'd2, 22'd2, 1'b0);
    step();
    chk("bp_ready2", {31'd0, bus.in_ready}, 32'd0);
    chk("bp_head_a", {10'd0, bus.out_sum}, 32'd2);
    offer(22'd3, 22'd3, 1'b0);
    step();
    chk("bp_hold_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("bp_hold_head", {10'd0, bus.out_sum}, 32'd2);
    bus.out_ready = 1'b1;
    step();
    chk("bp_pop_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("bp_head_b", {10'd0, bus.out_sum}, 32'd4);
    step();
    bus.in_valid = 1'b0;
    chk("bp_head_c", {10'd0, bus.out_sum}, 32'd6);
    step();
    chk("bp_drained", {31'd0, bus.out_valid}, 32'd0);

    // Random operands and handshake pressure; upstream holds data until accepted.
    offer_rand();
    sent = 0;
    for (int k = 0; k < 5000 && sent < 1000; k++) begin
      bus.out_ready = ($urandom_range(3) != 0);
      acc = bus.in_valid && bus.in_ready;
      step();
      if (acc) sent++;
      if (acc || !bus.in_valid) begin
        if ($urandom_range(4) != 0) offer_rand();
        else bus.in_valid = 1'b0;
      end
    end
    chk("rand_sent", sent, 32'd1000);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    step(); step(); step();

    // Full queue with steady offers while out_ready toggles.
    bus.out_ready = 1'b0;
    offer_rand();
    for (int k = 0; k < 60; k++) begin
      if (k >= 4) bus.out_ready = ~bus.out_ready;
      acc = bus.in_valid && bus.in_ready;
      step();
      if (acc) offer_rand();
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    step(); step(); step();

    // Run the pop counter up to its wrap point.
    offer_rand();
    for (int k = 0; k < 70000 && m_tx != 16'hFFFF; k++) begin
      step();
      offer_rand();
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    chk("wrap_pre", {16'd0, bus.tx_cnt}, 32'h0000FFFF);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("wrap_post", {16'd0, bus.tx_cnt}, 32'h00000000);
    chk("wrap_empty", {31'd0, bus.out_valid}, 32'd0);

    // Reset with two results queued discards them.
    offer_rand(); step();
    offer_rand(); step();
    bus.in_valid = 1'b0;
    chk("pre_rst_full", {31'd0, bus.in_ready}, 32'd0);
    rst_n = 1'b0;
    bus.out_ready = 1'b1;
    step();
    chk("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mid_rst_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("mid_rst_tx", {16'd0, bus.tx_cnt}, 32'd0);
    chk("mid_rst_sum", {10'd0, bus.out_sum}, 32'd0);
    chk("mid_rst_cout", {31'd0, bus.out_cout}, 32'd0);
    rst_n = 1'b1;
    step(); step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
